// File: rtl/ma_peak_detect.sv
// Threshold-triggered windowed peak search on the moving-average stream.
// Define MA_PEAK_DET_ABS_EN to compare sample magnitudes instead of signed values.
module ma_peak_detect #(
  parameter int DATA_W  = 71,
  parameter int CNT_W   = 16,
  parameter int WINDOW  = 32,
  parameter int HOLDOFF = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [DATA_W-1:0] ma_in,
  input  logic [DATA_W-1:0] threshold,
  input  logic              arm,
  output logic              det_valid,
  input  logic              det_ready,
  output logic [DATA_W-1:0] det_peak,
  output logic [CNT_W-1:0]  det_index,
  output logic              busy,
  output logic              overflow
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARMED,
    S_SEARCH,
    S_REPORT,
    S_HOLD
  } state_t;

  localparam int HW = (HOLDOFF > 1) ? $clog2(HOLDOFF + 1) : 1;
  localparam logic [CNT_W-1:0] WIN_L = CNT_W'(WINDOW);
  localparam logic [HW-1:0] HOLD_L = HW'(HOLDOFF);

  // Compare key: one bit wider so magnitude and signed modes share one signed compare.
  function automatic logic signed [DATA_W:0] key_f(
    input logic [DATA_W-1:0] v
  );
`ifdef MA_PEAK_DET_ABS_EN
    logic [DATA_W-1:0] m;
    if (!v[DATA_W-1])
      m = v;
    else if (v == {1'b1, {(DATA_W-1){1'b0}}})
      m = {1'b0, {(DATA_W-1){1'b1}}};
    else
      m = -v;
    return {1'b0, m};
`else
    return {v[DATA_W-1], v};
`endif
  endfunction

  state_t              state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [CNT_W-1:0]    win_q;
  logic [HW-1:0]       hcnt_q;
  logic [DATA_W-1:0]   peak_q;
  logic [CNT_W-1:0]    idx_q;
  logic [DATA_W-1:0]   dpk_q;
  logic [CNT_W-1:0]    dix_q;
  logic                dv_q;
  logic                ovf_q;
  logic                arm_q;

  logic signed [DATA_W:0] in_k;
  logic signed [DATA_W:0] thr_k;
  logic signed [DATA_W:0] pk_k;
  logic                   gt_thr;
  logic                   gt_pk;
  logic [CNT_W-1:0]       win_d;
  logic [DATA_W-1:0]      peak_d;
  logic [CNT_W-1:0]       idx_d;

  always_comb begin
    in_k = key_f(ma_in);
    pk_k = key_f(peak_q);
`ifdef MA_PEAK_DET_ABS_EN
    thr_k = {1'b0, threshold};
`else
    thr_k = {threshold[DATA_W-1], threshold};
`endif
    gt_thr = in_k > thr_k;
    gt_pk  = in_k > pk_k;
    win_d  = win_q + CNT_W'(1);
    peak_d = gt_pk ? ma_in : peak_q;
    idx_d  = gt_pk ? cnt_q : idx_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      win_q   <= '0;
      hcnt_q  <= '0;
      peak_q  <= '0;
      idx_q   <= '0;
      dpk_q   <= '0;
      dix_q   <= '0;
      dv_q    <= 1'b0;
      ovf_q   <= 1'b0;
      arm_q   <= 1'b0;
    end else begin
      arm_q <= arm;
      if (en)
        cnt_q <= cnt_q + CNT_W'(1);
      if (arm && !arm_q)
        ovf_q <= 1'b0;
      if (!arm) begin
        state_q <= S_IDLE;
        dv_q    <= 1'b0;
      end else begin
        unique case (state_q)
          S_IDLE: state_q <= S_ARMED;
          S_ARMED: begin
            if (en && gt_thr) begin
              peak_q <= ma_in;
              idx_q  <= cnt_q;
              win_q  <= CNT_W'(1);
              if (WINDOW == 1) begin
                state_q <= S_REPORT;
                dv_q    <= 1'b1;
                dpk_q   <= ma_in;
                dix_q   <= cnt_q;
              end else begin
                state_q <= S_SEARCH;
              end
            end
          end
          S_SEARCH: begin
            if (en) begin
              peak_q <= peak_d;
              idx_q  <= idx_d;
              win_q  <= win_d;
              if (win_d == WIN_L) begin
                state_q <= S_REPORT;
                dv_q    <= 1'b1;
                dpk_q   <= peak_d;
                dix_q   <= idx_d;
              end
            end
          end
          S_REPORT: begin
            if (en && gt_thr)
              ovf_q <= 1'b1;
            if (dv_q && det_ready) begin
              dv_q <= 1'b0;
              if (HOLDOFF == 0) begin
                state_q <= S_ARMED;
              end else begin
                state_q <= S_HOLD;
                hcnt_q  <= HOLD_L;
              end
            end
          end
          S_HOLD: begin
            if (en) begin
              hcnt_q <= hcnt_q - HW'(1);
              if (hcnt_q == HW'(1))
                state_q <= S_ARMED;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign det_valid = dv_q;
  assign det_peak  = dpk_q;
  assign det_index = dix_q;
  assign overflow  = ovf_q;
  assign busy      = (state_q == S_SEARCH) ||
                     (state_q == S_REPORT) ||
                     (state_q == S_HOLD);

endmodule

// File: tb/tb_ma_peak_detect.sv
// Directed bench for ma_peak_detect: window search, backpressure,
// overflow, abort, index wrap and asynchronous reset.
module tb_ma_peak_detect;

  localparam int DW = 71;
  localparam int CW = 4;

  logic          clk;
  logic          rst_n;
  logic          en;
  logic [DW-1:0] ma_in;
  logic [DW-1:0] threshold;
  logic          arm;
  logic          det_valid;
  logic          det_ready;
  logic [DW-1:0] det_peak;
  logic [CW-1:0] det_index;
  logic          busy;
  logic          overflow;

  int total;
  int bad;
  int vcnt;

  ma_peak_detect #(
    .DATA_W (DW),
    .CNT_W  (CW),
    .WINDOW (4),
    .HOLDOFF(2)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .ma_in    (ma_in),
    .threshold(threshold),
    .arm      (arm),
    .det_valid(det_valid),
    .det_ready(det_ready),
    .det_peak (det_peak),
    .det_index(det_index),
    .busy     (busy),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [79:0] got,
                     input logic [79:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input logic e, input logic signed [DW-1:0] v);
    en    = e;
    ma_in = v;
    @(posedge clk);
    #1;
    if (det_valid)
      vcnt++;
  endtask

  // Pulse reset, then one idle edge to move IDLE -> ARMED.
  task automatic do_rst();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n     = 1'b1;
    arm       = 1'b1;
    det_ready = 1'b1;
    step(1'b0, 0);
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    vcnt      = 0;
    rst_n     = 1'b0;
    en        = 1'b0;
    ma_in     = '0;
    threshold = 71'd10;
    arm       = 1'b1;
    det_ready = 1'b1;
    #12;
    chk("rst_dv", det_valid, 0);
    chk("rst_pk", det_peak, 0);
    chk("rst_ix", det_index, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ovf", overflow, 0);

    // basic report
    do_rst();
    vcnt = 0;
    step(1, 0);
    step(1, 5);
    chk("t1_armed_busy", busy, 0);
    step(1, 12);
    chk("t1_search_busy", busy, 1);
    step(1, 20);
    step(1, 15);
    chk("t1_dv_early", det_valid, 0);
    step(1, 8);
    chk("t1_dv", det_valid, 1);
    chk("t1_pk", det_peak, 20);
    chk("t1_ix", det_index, 3);
    step(1, 3);
    chk("t1_dv_ack", det_valid, 0);
    chk("t1_hold_busy", busy, 1);
    step(1, 1);
    chk("t1_hold1_busy", busy, 1);
    step(1, 1);
    chk("t1_rearm_busy", busy, 0);
    chk("t1_pulses", vcnt, 1);
    step(1, 11);
    chk("t1_retrig", busy, 1);

    // tie and backpressure
    do_rst();
    det_ready = 1'b0;
    step(1, 11);
    step(1, 30);
    step(1, 30);
    step(1, 2);
    chk("t2_dv", det_valid, 1);
    chk("t2_pk", det_peak, 30);
    chk("t2_ix", det_index, 1);
    for (int i = 0; i < 5; i++) begin
      step(0, 0);
      chk("t2_hold_dv", det_valid, 1);
      chk("t2_hold_pk", det_peak, 30);
      chk("t2_hold_ix", det_index, 1);
    end
    det_ready = 1'b1;
    step(0, 0);
    chk("t2_ack_dv", det_valid, 0);

    // overflow while stalled in REPORT
    do_rst();
    det_ready = 1'b0;
    step(1, 11);
    step(1, 12);
    step(1, 13);
    step(1, 14);
    chk("t3_pk", det_peak, 14);
    chk("t3_ovf0", overflow, 0);
    step(1, 50);
    chk("t3_ovf1", overflow, 1);
    chk("t3_pk_keep", det_peak, 14);
    det_ready = 1'b1;
    step(0, 0);
    chk("t3_ack_dv", det_valid, 0);
    chk("t3_ack_ovf", overflow, 1);
    arm = 1'b0;
    step(0, 0);
    chk("t3_idle_busy", busy, 0);
    chk("t3_idle_ovf", overflow, 1);
    arm = 1'b1;
    step(0, 0);
    chk("t3_clr_ovf", overflow, 0);

    // accept and crossing on the same edge
    do_rst();
    det_ready = 1'b0;
    step(1, 11);
    step(1, 12);
    step(1, 13);
    step(1, 14);
    det_ready = 1'b1;
    step(1, 50);
    chk("t3b_ovf", overflow, 1);
    chk("t3b_dv", det_valid, 0);
    step(1, 0);
    chk("t3b_hold", busy, 1);
    step(1, 0);
    chk("t3b_armed", busy, 0);

    // abort mid-search
    do_rst();
    step(1, 12);
    chk("t4_search", busy, 1);
    step(1, 13);
    arm = 1'b0;
    step(1, 1);
    chk("t4_abort_busy", busy, 0);
    chk("t4_abort_dv", det_valid, 0);
    arm = 1'b1;
    step(0, 0);
    step(1, 12);
    step(1, 0);
    step(1, 0);
    chk("t4_dv_early", det_valid, 0);
    step(1, 0);
    chk("t4_dv", det_valid, 1);
    chk("t4_pk", det_peak, 12);
    chk("t4_ix", det_index, 3);

    // negative samples never trigger; index wraps
    do_rst();
    for (int i = 0; i < 16; i++)
      step(1, -100);
    chk("t5_neg_busy", busy, 0);
    step(1, 40);
    step(1, 1);
    step(1, 1);
    step(1, 1);
    chk("t5_dv", det_valid, 1);
    chk("t5_pk", det_peak, 40);
    chk("t5_ix", det_index, 0);

    // async reset while in REPORT with overflow set
    do_rst();
    det_ready = 1'b0;
    step(1, 11);
    step(1, 12);
    step(1, 13);
    step(1, 14);
    step(1, 50);
    chk("t6_pre_ovf", overflow, 1);
    chk("t6_pre_dv", det_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_dv", det_valid, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_ovf", overflow, 0);
    chk("t6_rst_pk", det_peak, 0);
    @(negedge clk);
    rst_n     = 1'b1;
    det_ready = 1'b1;
    step(0, 0);
    step(1, 20);
    step(1, 1);
    step(1, 1);
    step(1, 1);
    chk("t6_dv", det_valid, 1);
    chk("t6_pk", det_peak, 20);
    chk("t6_ix", det_index, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
